// File: rtl/nand_op_sequencer.sv
// Multi-cycle logic-op sequencer: builds NAND/AND/OR/NOR/XOR/XNOR/NOTA/PASSA
// from one shared external bitwise NAND unit, one NAND evaluation per cycle.
module nand_op_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] nand_a,
   output logic [WIDTH-1:0] nand_b,
   input  logic [WIDTH-1:0] nand_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             busy
);

   localparam int unsigned STEP_W = 3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
   typedef enum logic [1:0] {D_T, D_P, D_Q, D_Y} dest_e;
   typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T, SRC_P, SRC_Q, SRC_Y} src_e;

   state_e            state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [2:0]        op_q, op_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]  t_q, t_d, p_q, p_d, q_q, q_d, y_q, y_d;

   src_e              src_a, src_b;
   dest_e             dest;
   logic              last;
   logic [WIDTH-1:0]  mux_a, mux_b;

   // Step table: operand sources, destination and last-step flag for (op, step)
   always_comb begin
      src_a = SRC_A;
      src_b = SRC_B;
      dest  = D_Y;
      last  = 1'b1;
      case (op_q)
         3'd1, 3'd7: begin
            if (step_q == STEP_W'(0)) begin
               dest = D_T;
               last = 1'b0;
               if (op_q == 3'd7) src_b = SRC_A;
            end else begin
               src_a = SRC_T;
               src_b = SRC_T;
            end
         end
         3'd2, 3'd3: begin
            case (step_q)
               STEP_W'(0): begin src_b = SRC_A; dest = D_P; last = 1'b0; end
               STEP_W'(1): begin src_a = SRC_B; dest = D_Q; last = 1'b0; end
               STEP_W'(2): begin src_a = SRC_P; src_b = SRC_Q; last = (op_q == 3'd2); end
               default:    begin src_a = SRC_Y; src_b = SRC_Y; end
            endcase
         end
         3'd4, 3'd5: begin
            case (step_q)
               STEP_W'(0): begin dest = D_T; last = 1'b0; end
               STEP_W'(1): begin src_b = SRC_T; dest = D_P; last = 1'b0; end
               STEP_W'(2): begin src_a = SRC_B; src_b = SRC_T; dest = D_Q; last = 1'b0; end
               STEP_W'(3): begin src_a = SRC_P; src_b = SRC_Q; last = (op_q == 3'd4); end
               default:    begin src_a = SRC_Y; src_b = SRC_Y; end
            endcase
         end
         3'd6:    src_b = SRC_A;
         default: ;
      endcase
   end

   // Operand source muxes
   always_comb begin
      mux_a = a_q;
      mux_b = b_q;
      case (src_a)
         SRC_B:   mux_a = b_q;
         SRC_T:   mux_a = t_q;
         SRC_P:   mux_a = p_q;
         SRC_Q:   mux_a = q_q;
         SRC_Y:   mux_a = y_q;
         default: mux_a = a_q;
      endcase
      case (src_b)
         SRC_A:   mux_b = a_q;
         SRC_T:   mux_b = t_q;
         SRC_P:   mux_b = p_q;
         SRC_Q:   mux_b = q_q;
         SRC_Y:   mux_b = y_q;
         default: mux_b = b_q;
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      t_d     = t_q;
      p_d     = p_q;
      q_d     = q_q;
      y_d     = y_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_RUN;
               step_d  = '0;
               op_d    = in_op;
               a_d     = in_a;
               b_d     = in_b;
            end
         end
         S_RUN: begin
            case (dest)
               D_T:     t_d = nand_y;
               D_P:     p_d = nand_y;
               D_Q:     q_d = nand_y;
               default: y_d = nand_y;
            endcase
            if (last) state_d = S_DONE;
            else      step_d  = step_q + STEP_W'(1);
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         t_q     <= '0;
         p_q     <= '0;
         q_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         t_q     <= t_d;
         p_q     <= p_d;
         q_q     <= q_d;
         y_q     <= y_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_y     = y_q;
   assign nand_a    = (state_q == S_RUN) ? mux_a : '0;
   assign nand_b    = (state_q == S_RUN) ? mux_b : '0;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer with a behavioural NAND unit.
module tb_nand_op_sequencer;

   localparam int unsigned WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a, in_b;
   logic [WIDTH-1:0] nand_a, nand_b, nand_y;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             busy;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] exp_pairs [8][5];

   nand_op_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .nand_a    (nand_a),
      .nand_b    (nand_b),
      .nand_y    (nand_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .busy      (busy)
   );

   assign nand_y = ~(nand_a & nand_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, track NAND pairs and latency, then optionally stall the output.
   task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_y, input int exp_n, input bit chk_pairs,
                         input int hold);
      int cnt;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      check($sformatf("op%0d in_ready_pre", op), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      in_a     = 16'h0000;
      in_b     = 16'hFFFF;
      cnt      = 0;
      while (!out_valid && cnt < 16) begin
         if (chk_pairs && cnt < 5)
            check($sformatf("op%0d pair%0d", op, cnt), {16'(nand_a), 16'(nand_b)},
                  exp_pairs[op][cnt]);
         tick();
         cnt++;
      end
      check($sformatf("op%0d latency", op), 32'(cnt), 32'(exp_n));
      check($sformatf("op%0d out_y", op), 32'(out_y), 32'(exp_y));
      check($sformatf("op%0d nand_idle", op), {16'(nand_a), 16'(nand_b)}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check($sformatf("op%0d stall_valid%0d", op, i), 32'(out_valid), 32'd1);
         check($sformatf("op%0d stall_y%0d", op, i), 32'(out_y), 32'(exp_y));
         check($sformatf("op%0d stall_rdy%0d", op, i), {30'd0, in_ready, busy}, 32'd1);
      end
      out_ready = 1'b1;
      tick();
      check($sformatf("op%0d back_idle", op), {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      exp_pairs[0][0] = 32'hF0F0FF00;
      exp_pairs[1][0] = 32'hA5A50FF0; exp_pairs[1][1] = 32'hFA5FFA5F;
      exp_pairs[2][0] = 32'hA5A5A5A5; exp_pairs[2][1] = 32'h0FF00FF0; exp_pairs[2][2] = 32'h5A5AF00F;
      exp_pairs[3][0] = 32'hA5A5A5A5; exp_pairs[3][1] = 32'h0FF00FF0; exp_pairs[3][2] = 32'h5A5AF00F;
      exp_pairs[3][3] = 32'hAFF5AFF5;
      exp_pairs[4][0] = 32'hA5A50FF0; exp_pairs[4][1] = 32'hA5A5FA5F; exp_pairs[4][2] = 32'h0FF0FA5F;
      exp_pairs[4][3] = 32'h5FFAF5AF;
      exp_pairs[5][0] = 32'hA5A50FF0; exp_pairs[5][1] = 32'hA5A5FA5F; exp_pairs[5][2] = 32'h0FF0FA5F;
      exp_pairs[5][3] = 32'h5FFAF5AF; exp_pairs[5][4] = 32'hAA55AA55;
      exp_pairs[6][0] = 32'hA5A5A5A5;
      exp_pairs[7][0] = 32'hA5A5A5A5; exp_pairs[7][1] = 32'h5A5A5A5A;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 3'd0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      #12;
      check("rst_ready_busy_valid", {29'd0, in_ready, busy, out_valid}, 32'd4);
      check("rst_out_y", 32'(out_y), 32'd0);
      check("rst_nand", {16'(nand_a), 16'(nand_b)}, 32'd0);
      rst_n = 1'b1;
      tick();

      run_op(3'd0, 16'hF0F0, 16'hFF00, 16'h0FFF, 1, 1'b1, 0);

      exp_pairs[0][0] = 32'hA5A50FF0;
      run_op(3'd0, 16'hA5A5, 16'h0FF0, 16'hFA5F, 1, 1'b1, 0);
      run_op(3'd1, 16'hA5A5, 16'h0FF0, 16'h05A0, 2, 1'b1, 0);
      run_op(3'd2, 16'hA5A5, 16'h0FF0, 16'hAFF5, 3, 1'b1, 0);
      run_op(3'd3, 16'hA5A5, 16'h0FF0, 16'h500A, 4, 1'b1, 0);
      run_op(3'd4, 16'hA5A5, 16'h0FF0, 16'hAA55, 4, 1'b1, 0);
      run_op(3'd5, 16'hA5A5, 16'h0FF0, 16'h55AA, 5, 1'b1, 0);
      run_op(3'd6, 16'hA5A5, 16'h0FF0, 16'h5A5A, 1, 1'b1, 0);
      run_op(3'd7, 16'hA5A5, 16'h0FF0, 16'hA5A5, 2, 1'b1, 0);

      run_op(3'd5, 16'hA5A5, 16'h0FF0, 16'h55AA, 5, 1'b1, 6);

      // Back-to-back XOR with in_valid held; operand A changes during RUN.
      begin
         int cnt;
         in_op = 3'd4; in_a = 16'hA5A5; in_b = 16'h0FF0;
         in_valid = 1'b1; out_ready = 1'b1;
         tick();
         in_a = 16'h1234;
         cnt = 0;
         while (!out_valid && cnt < 16) begin tick(); cnt++; end
         check("b2b first_latency", 32'(cnt), 32'd4);
         check("b2b first_y", 32'(out_y), 32'hAA55);
         check("b2b ready_in_done", 32'(in_ready), 32'd0);
         tick();
         check("b2b idle_after_hs", {30'd0, in_ready, busy}, 32'd2);
         tick();
         check("b2b second_accept", {30'd0, in_ready, busy}, 32'd1);
         in_valid = 1'b0;
         in_a = 16'hFFFF;
         cnt = 0;
         while (!out_valid && cnt < 16) begin tick(); cnt++; end
         check("b2b second_latency", 32'(cnt), 32'd4);
         check("b2b second_y", 32'(out_y), 32'h1DC4);
         tick();
      end

      // Asynchronous reset during step 2 of OR.
      in_op = 3'd2; in_a = 16'h00FF; in_b = 16'h0F0F;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("abort_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_flags", {29'd0, in_ready, busy, out_valid}, 32'd4);
      check("abort_out_y", 32'(out_y), 32'd0);
      check("abort_nand", {16'(nand_a), 16'(nand_b)}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_op(3'd1, 16'hFFFF, 16'h1234, 16'h1234, 2, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
